// File: rtl/predecode_sdr_seq.sv
// Registered SDR row predecoder with timed word-line strobes; optional burst via `PREDECODE_BURST_EN.
// Latency: predecode valid and first strobe 1 cycle after accept; 1-cycle RECOVER gap between beats.
// Backpressure: req_ready only in IDLE; enable=0 stalls the current beat without losing it.
module predecode_sdr_seq #(
  parameter int ADDR_BITS     = 5,
  parameter int STROBE_CYCLES = 1,
  parameter int BURST_BITS    = 3,
  parameter int NPAIR         = (ADDR_BITS - 1) / 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [0:ADDR_BITS-1]   req_addr,
  input  logic [BURST_BITS-1:0]  req_burst,
  input  logic                   enable,
  output logic                   c_na0,
  output logic                   c_a0,
  output logic [0:4*NPAIR-1]     pd_pair,
  output logic [1:0]             pd_tail,
  output logic                   beat_done,
  output logic                   busy
);

  localparam int SCW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [SCW-1:0] SC_LAST = SCW'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, RECOVER} state_t;

  state_t               state_q, state_d;
  logic [0:ADDR_BITS-1] addr_q;
  logic [SCW-1:0]       sc_q;
  logic                 pd_valid_q;
  logic                 accept, strobe, recover;

`ifdef PREDECODE_BURST_EN
  logic [BURST_BITS-1:0] beats_q;
  logic                  more_beats;
  assign more_beats = (beats_q != '0);
`else
  logic unused_burst;
  assign unused_burst = ^req_burst;
`endif

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    accept    = 1'b0;
    strobe    = 1'b0;
    beat_done = 1'b0;
    recover   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        // enable low freezes the beat: no strobe, no count, no completion
        if (enable) begin
          strobe = 1'b1;
          if (sc_q == SC_LAST) begin
            beat_done = 1'b1;
`ifdef PREDECODE_BURST_EN
            state_d = more_beats ? RECOVER : IDLE;
`else
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef PREDECODE_BURST_EN
      RECOVER: begin
        recover = 1'b1;
        state_d = ACTIVE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      sc_q       <= '0;
      pd_valid_q <= 1'b0;
`ifdef PREDECODE_BURST_EN
      beats_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= req_addr;
        sc_q       <= '0;
        pd_valid_q <= 1'b1;
`ifdef PREDECODE_BURST_EN
        beats_q    <= req_burst;
`endif
      end else if (strobe) begin
        sc_q <= sc_q + SCW'(1);
      end else if (recover) begin
        sc_q <= '0;
`ifdef PREDECODE_BURST_EN
        // leftmost bit is the MSB, so plain addition wraps through bit 0
        addr_q  <= addr_q + ADDR_BITS'(1);
        beats_q <= beats_q - BURST_BITS'(1);
`endif
      end
    end
  end

  assign busy  = (state_q != IDLE);
  assign c_na0 = strobe & ~addr_q[0];
  assign c_a0  = strobe &  addr_q[0];

  for (genvar k = 0; k < NPAIR; k++) begin : g_pair
    logic hi, lo;
    assign hi = addr_q[2*k+1];
    assign lo = addr_q[2*k+2];
    assign pd_pair[4*k+0] = pd_valid_q & ~hi & ~lo;
    assign pd_pair[4*k+1] = pd_valid_q & ~hi &  lo;
    assign pd_pair[4*k+2] = pd_valid_q &  hi & ~lo;
    assign pd_pair[4*k+3] = pd_valid_q &  hi &  lo;
  end

  if (((ADDR_BITS - 1) % 2) == 1) begin : g_tail
    assign pd_tail = {pd_valid_q & ~addr_q[ADDR_BITS-1], pd_valid_q & addr_q[ADDR_BITS-1]};
  end else begin : g_no_tail
    assign pd_tail = 2'b00;
  end

endmodule

// File: tb/tb_predecode_sdr_seq.sv
// Bench for predecode_sdr_seq: decode table plus burst, stall, handshake, reset and odd-width sequences.
module tb_predecode_sdr_seq;

`ifdef PREDECODE_BURST_EN
  localparam int NB = 4;
`else
  localparam int NB = 1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req_valid = 1'b0;
  logic enable = 1'b1;
  logic [2:0] req_burst = 3'd0;
  logic [0:4] req_addr5 = '0;
  logic [0:5] req_addr6 = '0;

  logic       rdy0, na0_0, a0_0, bd0, busy0;
  logic [0:7] pair0;
  logic [1:0] tail0;
  logic       rdy1, na0_1, a0_1, bd1, busy1;
  logic [0:7] pair1;
  logic [1:0] tail1;
  logic       rdy2, na0_2, a0_2, bd2, busy2;
  logic [0:7] pair2;
  logic [1:0] tail2;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  predecode_sdr_seq #(.ADDR_BITS(5), .STROBE_CYCLES(1), .BURST_BITS(3)) u0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy0),
    .req_addr(req_addr5), .req_burst(req_burst), .enable(enable),
    .c_na0(na0_0), .c_a0(a0_0), .pd_pair(pair0), .pd_tail(tail0),
    .beat_done(bd0), .busy(busy0));

  predecode_sdr_seq #(.ADDR_BITS(5), .STROBE_CYCLES(2), .BURST_BITS(3)) u1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy1),
    .req_addr(req_addr5), .req_burst(req_burst), .enable(enable),
    .c_na0(na0_1), .c_a0(a0_1), .pd_pair(pair1), .pd_tail(tail1),
    .beat_done(bd1), .busy(busy1));

  predecode_sdr_seq #(.ADDR_BITS(6), .STROBE_CYCLES(1), .BURST_BITS(3)) u2 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy2),
    .req_addr(req_addr6), .req_burst(req_burst), .enable(enable),
    .c_na0(na0_2), .c_a0(a0_2), .pd_pair(pair2), .pd_tail(tail2),
    .beat_done(bd2), .busy(busy2));

  typedef struct {
    logic [0:4] addr;
    logic [0:7] pair;
    logic       a0;
  } vec_t;

  typedef struct {
    logic en;
    logic stb;
    logic bd;
    logic bsy;
  } stall_t;

  vec_t       tbl[5];
  stall_t     stl[6];
  logic [0:7] exp_w[4];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = 1'b0;
    enable    = 1'b1;
    req_burst = 3'd0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int bd_cnt;
    int n, ph;
    logic stb;

    tbl[0] = '{5'b10110, 8'b0100_0010, 1'b1};
    tbl[1] = '{5'b00000, 8'b1000_1000, 1'b0};
    tbl[2] = '{5'b11111, 8'b0001_0001, 1'b1};
    tbl[3] = '{5'b01001, 8'b0010_0100, 1'b0};
    tbl[4] = '{5'b00111, 8'b0100_0001, 1'b0};

    stl[0] = '{1'b1, 1'b1, 1'b0, 1'b1};
    stl[1] = '{1'b0, 1'b0, 1'b0, 1'b1};
    stl[2] = '{1'b0, 1'b0, 1'b0, 1'b1};
    stl[3] = '{1'b0, 1'b0, 1'b0, 1'b1};
    stl[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    stl[5] = '{1'b1, 1'b0, 1'b0, 1'b0};

    exp_w[0] = 8'b0001_0010;
    exp_w[1] = 8'b0001_0001;
    exp_w[2] = 8'b1000_1000;
    exp_w[3] = 8'b1000_0100;

    // reset state
    do_reset();
    sample();
    chk("rst_ready", rdy0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_pair", pair0, 0);
    chk("rst_tail", tail0, 0);
    chk("rst_strobe", {na0_0, a0_0}, 0);
    chk("rst_beat_done", bd0, 0);
    chk("rst_tail6", tail2, 0);

    // single-beat decode table, STROBE_CYCLES=1
    for (int i = 0; i < 5; i++) begin
      step();
      req_valid = 1'b1;
      req_addr5 = tbl[i].addr;
      sample();
      chk("tbl_ready_T", rdy0, 1);
      step();
      req_valid = 1'b0;
      sample();
      chk("tbl_pair_T1", pair0, tbl[i].pair);
      chk("tbl_tail_T1", tail0, 0);
      chk("tbl_c_a0_T1", a0_0, tbl[i].a0);
      chk("tbl_c_na0_T1", na0_0, !tbl[i].a0);
      chk("tbl_beat_done_T1", bd0, 1);
      chk("tbl_busy_T1", busy0, 1);
      step();
      sample();
      chk("tbl_ready_T2", rdy0, 1);
      chk("tbl_strobe_T2", {na0_0, a0_0}, 0);
      chk("tbl_pair_hold_T2", pair0, tbl[i].pair);
    end

    // burst with wrap (STROBE_CYCLES=2) while a second request is held pending
    do_reset();
    step();
    req_valid = 1'b1;
    req_addr5 = 5'b11110;
    req_burst = 3'd3;
    sample();
    chk("hs_ready_T", rdy1, 1);
    step();
    req_addr5 = 5'b00010;
    req_burst = 3'd0;
    bd_cnt = 0;
    for (int c = 1; c <= NB * 3; c++) begin
      if (c > 1) step();
      sample();
      n   = (c - 1) / 3;
      ph  = (c - 1) % 3;
      stb = (ph < 2);
      if (bd1) bd_cnt++;
      chk("wrap_busy", busy1, (c < NB * 3) ? 1 : 0);
      chk("wrap_ready", rdy1, (c < NB * 3) ? 0 : 1);
      chk("wrap_c_a0", a0_1, (stb && n < 2) ? 1 : 0);
      chk("wrap_c_na0", na0_1, (stb && n >= 2) ? 1 : 0);
      chk("wrap_beat_done", bd1, (ph == 1) ? 1 : 0);
      chk("wrap_pair", pair1, exp_w[n]);
    end
    chk("wrap_beat_count", bd_cnt, NB);
    step();
    req_valid = 1'b0;
    sample();
    chk("hs_second_busy", busy1, 1);
    chk("hs_second_pair", pair1, 8'b1000_0010);
    chk("hs_second_c_na0", na0_1, 1);
    chk("hs_second_c_a0", a0_1, 0);
    step();
    sample();
    chk("hs_second_beat_done", bd1, 1);
    step();
    sample();
    chk("hs_second_ready", rdy1, 1);

    // enable stall: 3 low cycles after the first strobe cycle
    do_reset();
    step();
    req_valid = 1'b1;
    req_addr5 = 5'b01100;
    sample();
    for (int c = 0; c < 6; c++) begin
      step();
      req_valid = 1'b0;
      enable    = stl[c].en;
      sample();
      chk("stall_c_na0", na0_1, stl[c].stb);
      chk("stall_c_a0", a0_1, 0);
      chk("stall_beat_done", bd1, stl[c].bd);
      chk("stall_busy", busy1, stl[c].bsy);
      chk("stall_pair", pair1, 8'b0001_1000);
    end
    enable = 1'b1;

    // asynchronous reset during beat 2 of 4
    do_reset();
    step();
    req_valid = 1'b1;
    req_addr5 = 5'b11110;
    req_burst = 3'd3;
    sample();
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) step();
      sample();
    end
    chk("midrst_pre_c_na0", na0_1, (NB == 4) ? 1 : 0);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_ready", rdy1, 1);
    chk("midrst_busy", busy1, 0);
    chk("midrst_strobe", {na0_1, a0_1}, 0);
    chk("midrst_pair", pair1, 0);
    chk("midrst_beat_done", bd1, 0);
    step();
    reset_n = 1'b1;
    step();
    step();
    step();
    sample();
    chk("postrst_pair", pair1, 0);
    chk("postrst_tail", tail1, 0);
    chk("postrst_busy", busy1, 0);

    // odd address width
    do_reset();
    step();
    req_valid = 1'b1;
    req_addr6 = 6'b011011;
    sample();
    step();
    req_valid = 1'b0;
    sample();
    chk("odd_tail", tail2, 2'b01);
    chk("odd_pair", pair2, 8'b0001_0100);
    chk("odd_c_na0", na0_2, 1);
    chk("odd_c_a0", a0_2, 0);
    chk("odd_beat_done", bd2, 1);
    step();
    sample();
    chk("odd_strobe_off", na0_2, 0);
    chk("odd_tail_hold", tail2, 2'b01);
    chk("odd_ready", rdy2, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
